// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single RV32E register-file write port between two writeback
//   requesters. Port A (execute/ALU) is primary and port B (load/multicycle)
//   is secondary. At most one request is granted per cycle. The granted write
//   is registered onto rf_* and appears in the following cycle. A
//   combinational pending mask tells hazard logic which registers have a
//   write request waiting.
//
//   Optional feature (macro REGFILE_WR_ARB_FAIR_EN):
//     defined   - B takes priority after waiting STARVE_LIMIT consecutive
//                 eligible cycles.
//     undefined - strict priority. A always beats B.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   a_valid/a_ready       port A handshake; a_addr/a_data are the write target
//   b_valid/b_ready       port B handshake; b_addr/b_data are the write target
//   wr_stall              blocks every grant while high
//   rf_we/rf_addr/rf_data registered register-file write port
//   pending               bit i set while a valid request targets register i
//                         (bit 0 is always 0)
module regfile_write_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_data,
  input  logic                   wr_stall,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_addr,
  output logic [DATA_W-1:0]      rf_data,
  output logic [(1<<ADDR_W)-1:0] pending
);

  localparam int NREG = 1 << ADDR_W;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("regfile_write_arbiter: STARVE_LIMIT must be >= 1");
  end

  // High when B has waited long enough to override A.
  logic b_starved;

`ifdef REGFILE_WR_ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign b_starved = (starve_cnt == CNT_MAX);

  // Counts the cycles in which B was eligible but lost to A. Stalled cycles
  // do not count and do not clear the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (!b_valid || b_ready)
      starve_cnt <= '0;
    else if (!wr_stall && starve_cnt != CNT_MAX)
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign b_starved = 1'b0;
`endif

  // Grant depends only on inputs and the starvation state, never on rf_*.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!wr_stall) begin
      if (b_valid && b_starved) b_ready = 1'b1;
      else if (a_valid)         a_ready = 1'b1;
      else if (b_valid)         b_ready = 1'b1;
    end
  end

  // Write port register. A write to x0 completes its handshake but is never
  // enabled; the address and data still load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (a_ready) begin
      rf_we   <= (a_addr != '0);
      rf_addr <= a_addr;
      rf_data <= a_data;
    end else if (b_ready) begin
      rf_we   <= (b_addr != '0);
      rf_addr <= b_addr;
      rf_data <= b_data;
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // Pending mask of waiting requests. The write already registered onto
  // rf_* is excluded because the register file commits it this cycle.
  assign pending[0] = 1'b0;
  for (genvar i = 1; i < NREG; i++) begin : g_pend
    assign pending[i] = (a_valid && a_addr == ADDR_W'(i)) ||
                        (b_valid && b_addr == ADDR_W'(i));
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int LIM    = 4;
  localparam int NREG   = 16;
`ifdef REGFILE_WR_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, a_ready, b_valid, b_ready, wr_stall;
  logic [ADDR_W-1:0] a_addr, b_addr, rf_addr;
  logic [DATA_W-1:0] a_data, b_data, rf_data;
  logic              rf_we;
  logic [NREG-1:0]   pending;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_stall(wr_stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: how long B has been waiting, and the write the register
  // port should present in the next cycle.
  int          b_wait = 0;
  logic        m_we   = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check readies and pending against the
  // model, advance the model, then check the registered write port.
  task automatic cycle(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [31:0] bd,
                       input logic st,
                       output logic ga, output logic gb,
                       output logic oa, output logic ob, output logic [NREG-1:0] op);
    logic [NREG-1:0] ep;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    wr_stall = st;
    #1;
    ga = 1'b0; gb = 1'b0;
    if (!st) begin
      if (bv && FAIR && b_wait >= LIM) gb = 1'b1;
      else if (av)                     ga = 1'b1;
      else if (bv)                     gb = 1'b1;
    end
    ep = '0;
    for (int i = 1; i < NREG; i++)
      if ((av && aa == i[3:0]) || (bv && ba == i[3:0])) ep[i] = 1'b1;
    oa = a_ready; ob = b_ready; op = pending;
    chk("a_ready", {63'd0, a_ready}, {63'd0, ga});
    chk("b_ready", {63'd0, b_ready}, {63'd0, gb});
    chk("pending", {48'd0, pending}, {48'd0, ep});
    if (ga)      begin m_we = (aa != 0); m_addr = aa; m_data = ad; end
    else if (gb) begin m_we = (ba != 0); m_addr = ba; m_data = bd; end
    else         m_we = 1'b0;
    if (!bv || gb) b_wait = 0;
    else if (!st)  b_wait++;
    @(posedge clk);
    #1;
    chk("rf_we",   {63'd0, rf_we},   {63'd0, m_we});
    chk("rf_addr", {60'd0, rf_addr}, {60'd0, m_addr});
    chk("rf_data", {32'd0, rf_data}, {32'd0, m_data});
  endtask

  logic            ga, gb, oa, ob;
  logic [NREG-1:0] op;
  logic            ap, bp;
  logic [3:0]      raa, rba;
  logic [31:0]     rad, rbd;

  initial begin
    rst = 1'b0;
    a_valid = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_addr = '0; b_data = '0;
    wr_stall = 0;
    #12;
    chk("rst_rf_we",   {63'd0, rf_we},   64'd0);
    chk("rst_rf_addr", {60'd0, rf_addr}, 64'd0);
    chk("rst_rf_data", {32'd0, rf_data}, 64'd0);
    chk("rst_readies", {62'd0, a_ready, b_ready}, 64'd0);
    chk("rst_pending", {48'd0, pending}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single A write, then an idle cycle.
    cycle(1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 32'd0, 0, ga, gb, oa, ob, op);
    chk("t1_a_ready", {63'd0, oa}, 64'd1);
    chk("t1_rf", {27'd0, rf_we, rf_addr, rf_data}, {27'd0, 1'b1, 4'd5, 32'hDEADBEEF});
    cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, ga, gb, oa, ob, op);
    chk("t1_idle_we", {63'd0, rf_we}, 64'd0);

    // Contention: A (x3) held continuously, B (x7) held until granted.
    bp = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(1, 4'd3, 32'h300 + k, bp, 4'd7, 32'h7777, 0, ga, gb, oa, ob, op);
      chk($sformatf("contend_b%0d", k), {63'd0, ob}, {63'd0, (FAIR && k == 4)});
      if (gb) bp = 1'b0;
    end
    while (bp) begin
      cycle(0, 4'd0, 32'd0, 1, 4'd7, 32'h7777, 0, ga, gb, oa, ob, op);
      if (gb) bp = 1'b0;
    end

    // Write to x0: handshake completes, no enable, no pending bit.
    cycle(0, 4'd0, 32'd0, 1, 4'd0, 32'h1234, 0, ga, gb, oa, ob, op);
    chk("x0_b_ready", {63'd0, ob}, 64'd1);
    chk("x0_pend0",   {63'd0, op[0]}, 64'd0);
    chk("x0_rf", {27'd0, rf_we, rf_addr, rf_data}, {27'd0, 1'b0, 4'd0, 32'h1234});

    // Stall for three cycles, then release and drain.
    for (int k = 0; k < 3; k++) begin
      cycle(1, 4'd6, 32'hA6, 1, 4'd8, 32'hB8, 1, ga, gb, oa, ob, op);
      chk("stall_ready", {62'd0, oa, ob}, 64'd0);
      chk("stall_we",    {63'd0, rf_we}, 64'd0);
    end
    ap = 1'b1; bp = 1'b1;
    for (int k = 0; k < 12 && (ap || bp); k++) begin
      cycle(ap, 4'd6, 32'hA6, bp, 4'd8, 32'hB8, 0, ga, gb, oa, ob, op);
      if (ga) ap = 1'b0;
      if (gb) bp = 1'b0;
    end
    chk("stall_drain", {62'd0, ap, bp}, 64'd0);

    // Pending mask with two live requests.
    cycle(1, 4'd2, 32'h22, 1, 4'd9, 32'h99, 0, ga, gb, oa, ob, op);
    chk("pend_both", {48'd0, op}, 64'h0204);
    cycle(0, 4'd0, 32'd0, 1, 4'd9, 32'h99, 0, ga, gb, oa, ob, op);
    chk("pend_b_only", {48'd0, op}, 64'h0200);

    // Reset in the middle of a write, with B having built up some waiting.
    cycle(1, 4'd1, 32'h11, 1, 4'd10, 32'hAA, 0, ga, gb, oa, ob, op);
    cycle(1, 4'd4, 32'h44, 1, 4'd10, 32'hAA, 0, ga, gb, oa, ob, op);
    chk("rstmid_pre_we", {63'd0, rf_we}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_rf", {27'd0, rf_we, rf_addr, rf_data}, 64'd0);
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    rst = 1'b1;
    b_wait = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    // After release the counter restarts from zero: B wins only on cycle LIM.
    bp = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(1, 4'd3, 32'h55, bp, 4'd11, 32'hBB, 0, ga, gb, oa, ob, op);
      chk($sformatf("post_rst_b%0d", k), {63'd0, ob}, {63'd0, (FAIR && k == LIM)});
      if (gb) bp = 1'b0;
    end

    // Randomized traffic from two well-behaved requesters.
    ap = 1'b0; bp = 1'b0;
    raa = '0; rba = '0; rad = '0; rbd = '0;
    repeat (500) begin
      if (!ap && $urandom_range(3) != 0) begin
        ap = 1'b1; raa = 4'($urandom); rad = $urandom;
      end
      if (!bp && $urandom_range(3) != 0) begin
        bp = 1'b1; rba = 4'($urandom); rbd = $urandom;
      end
      cycle(ap, raa, rad, bp, rba, rbd, ($urandom_range(6) == 0), ga, gb, oa, ob, op);
      if (ga) ap = 1'b0;
      if (gb) bp = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the RV32E register file between two writeback requesters: port A (execute/ALU, primary) and port B (load/multicycle unit, secondary). Each requester uses a valid/ready handshake. The block selects at most one winner per cycle and drives the register file write port from registered outputs. It also publishes a pending-write mask so hazard logic can stall readers of registers with writes in flight.

## Interface
Parameters:
- ADDR_W, 4: register address width (16 registers).
- DATA_W, 32: register data width.
- STARVE_LIMIT, 4: consecutive cycles B may wait before it takes priority over A. Must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- a_valid  in  1  port A has a write request.
- a_ready  out  1  port A request accepted this cycle.
- a_addr  in  ADDR_W  port A destination register.
- a_data  in  DATA_W  port A write data.
- b_valid, b_ready, b_addr, b_data: same as port A, for port B.
- wr_stall  in  1  when high, no request is granted (external regfile access owns the port).
- rf_we  out  1  register file write enable.
- rf_addr  out  ADDR_W  register file write address.
- rf_data  out  DATA_W  register file write data.
- pending  out  2**ADDR_W  bit i is set while a valid request targets register i (i≠0).

## Operation
- Grant is combinational from inputs and state. A request is accepted on a cycle with valid && ready.
- Grant rule when wr_stall=0:
  - If b_valid && starve_cnt==STARVE_LIMIT, grant B.
  - Else if a_valid, grant A.
  - Else if b_valid, grant B.
  - Else no grant.
- When wr_stall=1: a_ready=b_ready=0 and starve_cnt holds its value.
- starve_cnt, width clog2(STARVE_LIMIT+1), reset value 0:
  - Increments and saturates at STARVE_LIMIT when b_valid && !b_ready && !wr_stall.
  - Clears to 0 on a B grant or when b_valid=0.
- Accepted write to x0 (addr==0): the handshake completes, but rf_we stays 0 on the next cycle. rf_addr and rf_data still load.
- Requesters must hold valid, addr and data stable until accepted. valid must not drop before acceptance.
- Same address on A and B in the same cycle: the winner is written first and the loser one or more cycles later, so the loser's data is final. Requesters resolve WAW ordering themselves.
- pending = onehot(a_addr)&{a_valid} | onehot(b_addr)&{b_valid}, with bit 0 forced to 0. It is combinational and drops in the cycle after acceptance, when valid deasserts. The in-flight registered output is not included; the register file commits it at the next edge.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_data=0, starve_cnt=0. a_ready and b_ready follow inputs combinationally (both 0 if both valids are 0).
- Latency: request accepted in cycle N, then rf_we/rf_addr/rf_data present in cycle N+1, then the register file updates at the end of N+1.
- Throughput: one write per cycle. rf_we is 0 in any cycle following a no-grant cycle.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). A write registered but not yet committed is discarded. Requesters re-present after reset.
- No combinational path from rf_* outputs to the ready signals.

## Configuration
- REGFILE_WR_ARB_FAIR_EN defined: starvation counter and B-priority override as above.
- Not defined: strict priority, A always beats B. starve_cnt logic is removed, and B can starve indefinitely under continuous a_valid. All other behaviour is identical.

## Test plan
- Single A write: a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle → a_ready=1 in that cycle; next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; following cycle rf_we=0.
- Contention with fairness, STARVE_LIMIT=4: a_valid held 1 (addr 3) and b_valid=1 (addr 7) from cycle 0 → A granted in cycles 0–3, B granted in cycle 4, A again in cycle 5; without the macro, B is never granted while a_valid=1.
- x0 write: b_valid=1, b_addr=0, b_data=0x1234 → b_ready=1; next cycle rf_we=0; pending[0]=0 throughout.
- wr_stall: both valids=1 and wr_stall=1 for 3 cycles → both readies=0, rf_we=0, starve_cnt unchanged; after release the grant rule resumes.
- pending mask: a_addr=2 and b_addr=9 both valid → pending=0x0204; after A is accepted, pending=0x0200 on the next cycle.
- Reset mid-write: accept A (addr 4) in cycle N, assert rst low during N+1 before the edge → rf_we=0, rf_addr=0, rf_data=0 immediately; starve_cnt=0 after release.
